// File: rtl/serial_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : serial_result_writer
// Brief    : Buffers PE results and writes them one byte per cycle to the
//            8-bit result memory; SERIAL_WR_SATURATE_EN selects 1-byte mode.
// Revision : 1.0
// ============================================================================
module serial_result_writer #(
    parameter int RES_W      = 16,
    parameter int ADDR_W     = 6,
    parameter int NUM_RES    = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [7:0]        result_baseaddr,
    input  logic              res_valid,
    input  logic [RES_W-1:0]  res_data,
    output logic              res_ready,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        d,
    output logic              busy,
    output logic              is_done_o
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_IDX_W = $clog2(NUM_RES + 1);

    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_RES - 1);
    localparam logic [c_IDX_W-1:0] c_NUM_RES  = c_IDX_W'(NUM_RES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_WR_LO = 3'd2,
        S_WR_HI = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    logic [RES_W-1:0]     r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_IDX_W-1:0]   r_res_idx;
    logic [c_IDX_W-1:0]   r_acc_cnt;
    logic [7:0]           r_base;
    logic [RES_W-1:0]     r_hold;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_last;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_final;
    logic [7:0]           w_idx8;
    logic [7:0]           w_addr_lo;
    logic [7:0]           w_addr_hi;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_last  = (r_res_idx == c_LAST_IDX);
    assign w_idx8  = 8'(r_res_idx);

    // Only accept while a job is armed, and never more than one job's worth.
    assign res_ready = ((r_state == S_ARM) || (r_state == S_WR_LO) || (r_state == S_WR_HI))
                       && !w_full && (r_acc_cnt != c_NUM_RES);
    assign w_push    = res_valid && res_ready;

`ifdef SERIAL_WR_SATURATE_EN
    assign w_addr_lo = r_base + w_idx8;
    assign w_final   = (r_state == S_WR_LO);

    function automatic logic [7:0] sat8(input logic [RES_W-1:0] v);
        logic [7:0] r;
        if (!v[RES_W-1] && (|v[RES_W-2:7]))
            r = 8'h7F;
        else if (v[RES_W-1] && !(&v[RES_W-2:7]))
            r = 8'h80;
        else
            r = v[7:0];
        return r;
    endfunction
`else
    assign w_addr_lo = r_base + (w_idx8 << 1);
    assign w_final   = (r_state == S_WR_HI);
`endif
    assign w_addr_hi = w_addr_lo + 8'd1;

    always_comb begin
        w_pop = 1'b0;
        if (r_state == S_ARM)
            w_pop = !w_empty;
        else if (w_final)
            w_pop = !w_empty && !w_last;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= res_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_res_idx <= '0;
            r_acc_cnt <= '0;
            r_base    <= '0;
            r_hold    <= '0;
            we        <= 1'b0;
            addr      <= '0;
            d         <= '0;
            busy      <= 1'b0;
            is_done_o <= 1'b0;
        end else begin
            we        <= 1'b0;
            is_done_o <= 1'b0;

            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_acc_cnt <= r_acc_cnt + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_hold   <= r_fifo[r_rd_ptr];
            end
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        // Start from a clean FIFO so nothing from an older job leaks in.
                        r_base    <= result_baseaddr;
                        r_res_idx <= '0;
                        r_acc_cnt <= '0;
                        r_wr_ptr  <= '0;
                        r_rd_ptr  <= '0;
                        r_count   <= '0;
                        busy      <= 1'b1;
                        r_state   <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (w_pop)
                        r_state <= S_WR_LO;
                end
                S_WR_LO: begin
                    we   <= 1'b1;
                    addr <= w_addr_lo[ADDR_W-1:0];
`ifdef SERIAL_WR_SATURATE_EN
                    d    <= sat8(r_hold);
`else
                    d    <= r_hold[7:0];
                    r_state <= S_WR_HI;
`endif
                end
                S_WR_HI: begin
                    we   <= 1'b1;
                    addr <= w_addr_hi[ADDR_W-1:0];
                    d    <= r_hold[15:8];
                end
                S_DONE: begin
                    is_done_o <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // The last byte of a result decides whether to finish, chain or wait.
            if (w_final) begin
                r_res_idx <= r_res_idx + 1'b1;
                if (w_last)
                    r_state <= S_DONE;
                else if (w_pop)
                    r_state <= S_WR_LO;
                else
                    r_state <= S_ARM;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_result_writer
// Brief    : Randomized self-checking bench for serial_result_writer.
// Revision : 1.0
// ============================================================================
module tb_serial_result_writer;

    localparam int RES_W      = 16;
    localparam int ADDR_W     = 6;
    localparam int NUM_RES    = 9;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic [7:0]        result_baseaddr = 8'h00;
    logic              res_valid = 1'b0;
    logic [RES_W-1:0]  res_data = '0;
    logic              res_ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        d;
    logic              busy;
    logic              is_done_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] res_vals [NUM_RES];

    serial_result_writer #(
        .RES_W      (RES_W),
        .ADDR_W     (ADDR_W),
        .NUM_RES    (NUM_RES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .result_baseaddr (result_baseaddr),
        .res_valid       (res_valid),
        .res_data        (res_data),
        .res_ready       (res_ready),
        .we              (we),
        .addr            (addr),
        .d               (d),
        .busy            (busy),
        .is_done_o       (is_done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sat_byte(input logic [15:0] v);
        int s;
        s = $signed(v);
        if (s > 127)  return 8'h7F;
        if (s < -128) return 8'h80;
        return v[7:0];
    endfunction

    function automatic logic [15:0] rand_res();
        if ($urandom_range(1) == 0)
            return 16'($urandom);
        return 16'($urandom_range(400)) - 16'd200;
    endfunction

    task automatic fill_random(input int from);
        for (int i = from; i < NUM_RES; i++)
            res_vals[i] = rand_res();
    endtask

    // One job: producer honours valid/ready, every write is compared against
    // the byte stream the memory should receive for these results.
    task automatic run_job(input logic [7:0] base, input int vprob, input bit poke_en);
        logic [ADDR_W-1:0] exp_addr [$];
        logic [7:0]        exp_d [$];
        logic [7:0]        a8;
        int sent, wi, cyc, first_acc, first_we, last_we;
        bit acc, done_seen, stalled;

        for (int i = 0; i < NUM_RES; i++) begin
`ifdef SERIAL_WR_SATURATE_EN
            a8 = base + 8'(i);
            exp_addr.push_back(a8[ADDR_W-1:0]);
            exp_d.push_back(sat_byte(res_vals[i]));
`else
            a8 = base + 8'(2 * i);
            exp_addr.push_back(a8[ADDR_W-1:0]);
            exp_d.push_back(res_vals[i][7:0]);
            a8 = base + 8'(2 * i + 1);
            exp_addr.push_back(a8[ADDR_W-1:0]);
            exp_d.push_back(res_vals[i][15:8]);
`endif
        end

        @(negedge clk);
        en = 1'b1;
        result_baseaddr = base;
        @(negedge clk);
        en = 1'b0;
        result_baseaddr = 8'h00;
        chk("busy_after_en", 32'(busy), 32'd1);

        sent = 0; wi = 0; cyc = 0; acc = 1'b0; done_seen = 1'b0; stalled = 1'b0;
        first_acc = -1; first_we = -1; last_we = -1;
        while (!done_seen && cyc < 500) begin
            if (we) begin
                if (wi < exp_addr.size()) begin
                    chk("wr_addr", 32'(addr), 32'(exp_addr[wi]));
                    chk("wr_data", 32'(d), 32'(exp_d[wi]));
                end else begin
                    chk("write_overrun", 32'(wi), 32'(exp_addr.size() - 1));
                end
                if (first_we < 0) first_we = cyc;
                last_we = cyc;
                wi++;
            end
            if (is_done_o) begin
                done_seen = 1'b1;
                chk("writes_at_done", 32'(wi), 32'(exp_addr.size()));
                chk("done_after_last_we", 32'(cyc), 32'(last_we + 1));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
            if (acc) sent++;
            if (sent == NUM_RES && !done_seen)
                chk("ready_low_past_quota", 32'(res_ready), 32'd0);

            if (!(res_valid && !acc)) begin
                if (sent >= NUM_RES) begin
                    res_valid = 1'b1;          // extra result that must be refused
                    res_data  = 16'hDEAD;
                end else if ($urandom_range(99) < 32'(vprob)) begin
                    res_valid = 1'b1;
                    res_data  = res_vals[sent];
                end else begin
                    res_valid = 1'b0;
                end
            end
            if (busy && res_valid && !res_ready && sent < NUM_RES) stalled = 1'b1;
            acc = res_valid && res_ready;
            if (acc && first_acc < 0) first_acc = cyc;
            if (poke_en && cyc == 6) begin
                en = 1'b1;
                result_baseaddr = 8'h40;
            end else begin
                en = 1'b0;
                result_baseaddr = 8'h00;
            end
            @(negedge clk);
            cyc++;
        end
        res_valid = 1'b0;
        en = 1'b0;
        chk("job_completed", 32'(done_seen), 32'd1);
        if (vprob == 100) begin
            // first_acc marks the negedge before the accepting edge, so the
            // two-cycle push-to-write latency appears here as three.
            chk("first_write_latency", 32'(first_we - first_acc), 32'd3);
            chk("no_bubbles", 32'(last_we - first_we + 1), 32'(exp_addr.size()));
`ifndef SERIAL_WR_SATURATE_EN
            chk("backpressure_seen", 32'(stalled), 32'd1);
`endif
        end
        @(negedge clk);
        chk("done_single_pulse", 32'(is_done_o), 32'd0);
        chk("idle_no_we", 32'(we), 32'd0);
    endtask

    task automatic reset_mid_job();
        int cyc;
        bit hit;
        fill_random(0);
        @(negedge clk);
        en = 1'b1;
        result_baseaddr = 8'h20;
        @(negedge clk);
        en = 1'b0;
        res_valid = 1'b1;
        res_data = 16'h5A5A;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < 50) begin
            if (we) begin
                // First low byte on the bus: the writer is now on the high byte.
                rst = 1'b0;
                #1;
                chk("rst_we", 32'(we), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_ready", 32'(res_ready), 32'd0);
                chk("rst_addr", 32'(addr), 32'd0);
                chk("rst_d", 32'(d), 32'd0);
                hit = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("reset_reached_write", 32'(hit), 32'd1);
        res_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_we", 32'(we), 32'd0);
        chk("reset_addr", 32'(addr), 32'd0);
        chk("reset_d", 32'(d), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(is_done_o), 32'd0);
        chk("reset_ready", 32'(res_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NUM_RES; i++)
            res_vals[i] = 16'((i + 1) * 257);
        run_job(8'h10, 100, 1'b0);

        res_vals[0] = 16'hABCD;
        fill_random(1);
        run_job(8'hFE, 100, 1'b0);

        res_vals[0] = 16'h0200;
        res_vals[1] = 16'hFF00;
        res_vals[2] = 16'h0005;
        fill_random(3);
        run_job(8'h08, 100, 1'b0);

        fill_random(0);
        run_job(8'h05, 70, 1'b1);

        reset_mid_job();
        fill_random(0);
        run_job(8'h00, 100, 1'b0);

        for (int j = 0; j < 12; j++) begin
            fill_random(0);
            run_job(8'($urandom), int'($urandom_range(30, 100)), 1'($urandom_range(1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
